// File: rtl/pc_gen.sv
// Program counter generator: reset sequencing, sequential fetch advance,
// prioritised exception/jump/branch redirects and misaligned-target trapping.
module pc_gen #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(32'h0000_0100),
  parameter int unsigned     INC       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            if_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_offset,
  input  logic            jmp_en,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            exc_req,
  output logic [XLEN-1:0] pc,
  output logic            ce,
  output logic [XLEN-1:0] epc,
  output logic            misalign
);

  // INC is a power of two, so INC-1 masks exactly the granule offset bits;
  // with INC=1 the mask is zero and no target can be misaligned.
  localparam logic [XLEN-1:0] STEP       = XLEN'(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            ce_q;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] target;
  logic            redirect;
  logic            target_bad;
  logic            accept;

  assign redirect   = jmp_en | br_taken;
  assign target     = jmp_en ? jmp_target : pc_q + br_offset;
  assign target_bad = |(target & ALIGN_MASK);
  assign accept     = ce_q & if_ready & ~stall;

  // NOTE: every always_comb output gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;
    if (ce_q) begin
      if (exc_req) begin
        pc_d  = EXC_VEC;
        epc_d = pc_q;
      end else if (redirect) begin
        if (target_bad) begin
          pc_d       = EXC_VEC;
          epc_d      = target;
          misalign_d = 1'b1;
        end else begin
          pc_d = target;
        end
      end else if (accept) begin
        pc_d = pc_q + STEP;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      ce_q       <= 1'b0;
      epc_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ce_q       <= 1'b1;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc       = pc_q;
  assign ce       = ce_q;
  assign epc      = epc_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios plus random traffic, each
// cycle's expected outputs queued by a behavioural model and checked by a monitor.
module tb_pc_gen;

  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam logic [31:0] EXC_VEC   = 32'h0000_0100;
  localparam int unsigned INC       = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        if_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_offset = '0;
  logic        jmp_en = 1'b0;
  logic [31:0] jmp_target = '0;
  logic        exc_req = 1'b0;
  logic [31:0] pc;
  logic        ce;
  logic [31:0] epc;
  logic        misalign;

  pc_gen #(
    .XLEN(32), .RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC), .INC(INC)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .if_ready(if_ready),
    .br_taken(br_taken), .br_offset(br_offset), .jmp_en(jmp_en),
    .jmp_target(jmp_target), .exc_req(exc_req),
    .pc(pc), .ce(ce), .epc(epc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        ce;
    logic [31:0] epc;
    logic        mis;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    compared = 0;
  int    mismatched = 0;

  // Reference model state: architectural view of the generator.
  logic [31:0] m_pc = '0;
  logic        m_ce = 1'b0;
  logic [31:0] m_epc = '0;
  logic        m_mis = 1'b0;

  task automatic model_step(input logic r, input logic st, input logic rdy,
                            input logic br, input logic [31:0] off,
                            input logic jmp, input logic [31:0] tgt,
                            input logic exc);
    longint unsigned dest;
    if (r) begin
      m_pc = RESET_VEC; m_ce = 1'b0; m_epc = '0; m_mis = 1'b0;
      return;
    end
    m_mis = 1'b0;
    if (m_ce) begin
      if (exc) begin
        m_epc = m_pc;
        m_pc  = EXC_VEC;
      end else if (jmp || br) begin
        if (jmp) dest = 64'(tgt);
        else     dest = (64'(m_pc) + 64'(off)) % 64'h1_0000_0000;
        if (dest % INC != 0) begin
          m_epc = 32'(dest);
          m_pc  = EXC_VEC;
          m_mis = 1'b1;
        end else begin
          m_pc = 32'(dest);
        end
      end else if (rdy && !st) begin
        m_pc = 32'((64'(m_pc) + INC) % 64'h1_0000_0000);
      end
    end
    m_ce = 1'b1;
  endtask

  // One clock of stimulus; glitch adds a sub-cycle rst pulse between edges.
  task automatic step(input logic r, input logic st, input logic rdy,
                      input logic br, input logic [31:0] off,
                      input logic jmp, input logic [31:0] tgt,
                      input logic exc, input logic glitch, input string tag);
    @(negedge clk);
    rst = r; stall = st; if_ready = rdy; br_taken = br; br_offset = off;
    jmp_en = jmp; jmp_target = tgt; exc_req = exc;
    model_step(r, st, rdy, br, off, jmp, tgt, exc);
    exp_q.push_back(obs_t'{m_pc, m_ce, m_epc, m_mis});
    tag_q.push_back(tag);
    if (glitch) begin
      #1 rst = 1'b1;
      #1 rst = r;
    end
  endtask

  task automatic go(input logic [31:0] tgt, input string tag);
    step(0, 0, 1, 0, 0, 1, tgt, 0, 0, tag);
  endtask

  // Monitor: compares the oldest expectation just after each active edge.
  initial begin
    obs_t  e;
    obs_t  got;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        got = obs_t'{pc, ce, epc, misalign};
        compared++;
        if (got !== e) begin
          mismatched++;
          $display("FAIL %s: got pc=%h ce=%b epc=%h misalign=%b, want pc=%h ce=%b epc=%h misalign=%b",
                   t, got.pc, got.ce, got.epc, got.mis, e.pc, e.ce, e.epc, e.mis);
        end
      end
    end
  end

  initial begin
    logic [31:0] r32;
    logic [31:0] off;
    logic [31:0] tgt;

    // Reset for two cycles, then sequential fetch 0,4,8,12...
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, "reset_hold");
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, "reset_hold");
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 0, 0, 0, "reset_seq");

    // Stall holds pc for three cycles, release advances.
    go(32'h10, "jmp_0x10");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0, 0, 0, "stall_hold");
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, "stall_release");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "not_ready_hold");

    // Branch under stall, then jump beats branch.
    go(32'h20, "jmp_0x20");
    step(0, 1, 1, 1, 32'hFFFF_FFF0, 0, 0, 0, 0, "br_neg_under_stall");
    step(0, 0, 1, 1, 32'h0000_0008, 1, 32'h40, 0, 0, "jmp_over_br");

    // Misaligned jump traps with a single-cycle misalign pulse.
    go(32'h30, "jmp_0x30");
    go(32'h42, "jmp_misaligned");
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, "misalign_drop");
    step(0, 0, 1, 1, 32'h3, 0, 0, 0, 0, "br_misaligned");
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, "after_br_misaligned");

    // Exception outranks a misaligned jump.
    go(32'h50, "jmp_0x50");
    step(0, 0, 1, 0, 0, 1, 32'h43, 1, 0, "exc_over_misaligned_jmp");
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, "after_exc");

    // Wrap at the top of the address space, then reset during a redirect.
    go(32'hFFFF_FFFC, "jmp_top");
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, "pc_wrap");
    step(1, 0, 1, 0, 0, 1, 32'h80, 1, 0, "reset_over_redirect");
    step(0, 0, 1, 0, 0, 1, 32'h80, 1, 0, "ignored_while_ce0");
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, "rst_glitch_ignored");
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, "rst_glitch_ignored");

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      r32 = $urandom;
      off = {{24{r32[7]}}, r32[7:0]};
      if ($urandom_range(0, 3) != 0) off[1:0] = 2'b00;
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0, off,
           $urandom_range(0, 7) == 0, tgt, $urandom_range(0, 15) == 0,
           0, "random");
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d outstanding expectations, want 0", exp_q.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
